// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bcd_pkg
// Purpose : Shared types and constants for the sequential binary-to-BCD
//           (shift-and-add-3) conversion controller.
// Contents: bcd_state_e    - controller state encoding (IDLE, SHIFT)
//           BCD_DIGIT_W    - bits per BCD digit
//           BCD_ADD3_THRESH- digit value at or above which +3 is applied
//           pow10()        - saturating 10^n, used for elaboration checks
// Revision: 1.0 - initial release
// ============================================================================
package bcd_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bcd_state_e;

  localparam int BCD_DIGIT_W     = 4;
  localparam int BCD_ADD3_THRESH = 5;

  // Saturates at all-ones once 10^n no longer fits in 64 bits, which keeps
  // the digit-count legality check meaningful for large D.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      if (r > 64'd1844674407370955161) r = '1;
      else                             r = r * 64'd10;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
// Module  : bcd_add3
// Purpose : One digit of the double-dabble correction step: adds 3 to a BCD
//           digit whose value is 5 or more, otherwise passes it through.
// Ports   : din  [3:0] in  - scratch digit before correction
//           dout [3:0] out - corrected digit
// Revision: 1.0 - initial release
// ============================================================================
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  localparam logic [BCD_DIGIT_W-1:0] c_thresh = BCD_DIGIT_W'(BCD_ADD3_THRESH);
  localparam logic [BCD_DIGIT_W-1:0] c_three  = BCD_DIGIT_W'(3);

  // A digit never exceeds 9 entering this stage, so the sum peaks at 12 and
  // cannot wrap.
  assign dout = (din >= c_thresh) ? (din + c_three) : din;

endmodule
`default_nettype wire

// File: rtl/bcd_convert_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : bcd_convert_ctrl
// Purpose : Sequential W-bit binary to D-digit BCD converter (shift-and-add-3),
//           one input bit per clock, with a start/busy/done handshake.
// Params  : W - binary width (>= 4); D - BCD digits (10^D must exceed 2^W-1)
// Ports   : clk   in        - rising-edge clock
//           rst_n in        - asynchronous active-low reset
//           start in        - conversion request, honoured only when idle
//           bin   in  [W]   - operand, captured on the accepting edge
//           busy  out       - conversion in progress
//           done  out       - one-cycle pulse, new bcd value valid
//           bcd   out [4D]  - packed result, digit 0 in bits [3:0]
//           blank out [D]   - leading-zero blank mask (BCD_BLANK_EN only)
// Macros  : BCD_BLANK_EN - adds the registered leading-zero blank output
// Revision: 1.0 - initial release
// ============================================================================
module bcd_convert_ctrl
  import bcd_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   bin,
  output logic           busy,
  output logic           done,
`ifdef BCD_BLANK_EN
  output logic [4*D-1:0] bcd,
  output logic [D-1:0]   blank
`else
  output logic [4*D-1:0] bcd
`endif
);

  localparam int CNT_W = $clog2(W);
  localparam int BW    = BCD_DIGIT_W * D;

  // Illegal parameter combinations stop elaboration.
  if (W < 4 || W > 63) begin : g_w_check
    $error("bcd_convert_ctrl: W=%0d outside supported range 4..63", W);
  end
  if (pow10(D) <= ((64'd1 << W) - 64'd1)) begin : g_d_check
    $error("bcd_convert_ctrl: D=%0d digits cannot hold a %0d-bit value", D, W);
  end

  bcd_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]      shift_q, shift_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [BW-1:0]     bcd_q, bcd_d;

  logic [BW-1:0]     corr;
  logic [BW+W-1:0]   shift_cat;
  logic              last_iter;

  for (genvar i = 0; i < D; i++) begin : g_digit
    bcd_add3 u_add3 (
      .din  (scratch_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (corr[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Correct first, then shift the whole {scratch, operand} chain left by one.
  assign shift_cat = {corr, shift_q} << 1;
  assign last_iter = (cnt_q == CNT_W'(W - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bcd_d     = bcd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = shift_cat[BW+W-1:W];
        shift_d   = shift_cat[W-1:0];
        cnt_d     = cnt_q + 1'b1;
        if (last_iter) begin
          bcd_d   = shift_cat[BW+W-1:W];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      bcd_q     <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

`ifdef BCD_BLANK_EN
  // Digit 0 is never blanked so a zero result still shows a single "0".
  localparam logic [D-1:0] c_blank_rst = ~(D'(1));

  logic [D-1:0] blank_q, blank_d;
  logic         zero_above;

  // Walk from the most significant digit down; a digit blanks only while it
  // and everything above it are zero. Evaluated on the value bcd will load.
  always_comb begin
    blank_d    = blank_q;
    zero_above = 1'b1;
    if (state_q == SHIFT && last_iter) begin
      blank_d[0] = 1'b0;
      for (int k = D - 1; k >= 1; k--) begin
        zero_above = zero_above &
                     (shift_cat[W + k*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
        blank_d[k] = zero_above;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blank_q <= c_blank_rst;
    else        blank_q <= blank_d;
  end

  assign blank = blank_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bcd_convert_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_bcd_convert_ctrl
// Purpose : Self-checking bench for bcd_convert_ctrl (W=8, D=3). Expected BCD
//           values come from a divide-by-ten reference and travel through a
//           scoreboard queue from the launch point to the done pulse.
// Macros  : BCD_BLANK_EN - also checks the blank output
// Revision: 1.0 - initial release
// ============================================================================
module tb_bcd_convert_ctrl;

  localparam int W = 8;
  localparam int D = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   bin;
  logic           busy;
  logic           done;
  logic [4*D-1:0] bcd;
`ifdef BCD_BLANK_EN
  logic [D-1:0]   blank;
`endif

  int errors = 0;
  int checks = 0;
  logic [4*D-1:0] exp_q[$];

  always #5 clk = ~clk;

  bcd_convert_ctrl #(.W(W), .D(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
`ifdef BCD_BLANK_EN
    .bcd   (bcd),
    .blank (blank)
`else
    .bcd   (bcd)
`endif
  );

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int k = 0; k < D; k++) begin
      r[k*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [D-1:0] blank_of(input int v);
    logic [D-1:0] r;
    int p;
    r = '0;
    p = 10;
    for (int k = 1; k < D; k++) begin
      r[k] = (v < p);
      p = p * 10;
    end
    return r;
  endfunction

  // Call just after a negedge: start is sampled at the next posedge (edge 0),
  // then bin is scrambled to show later changes are ignored.
  task automatic launch(input logic [W-1:0] v);
    start = 1'b1;
    bin   = v;
    exp_q.push_back(to_bcd(int'(v)));
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = ~v;
  endtask

  // Counts negedges until done is seen or the budget runs out.
  task automatic wait_done(input int budget, output bit got,
                           output int busy_cycles, output int cycles);
    got = 1'b0;
    busy_cycles = 0;
    cycles = 0;
    while (!got && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (done) got = 1'b1;
      else if (busy) busy_cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (bcd !== '0) begin errors++; $display("FAIL reset_bcd: got %h want 000", bcd); end
`ifdef BCD_BLANK_EN
    checks++; if (blank !== 3'b110) begin errors++; $display("FAIL reset_blank: got %b want 110", blank); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit got;
    int bc, cyc;
    logic [4*D-1:0] e;
    launch(8'd255);
    wait_done(30, got, bc, cyc);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL single_done: got %b want 1", got); end
    checks++; if (bc != W) begin errors++; $display("FAIL single_busy_cycles: got %0d want %0d", bc, W); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_at_done: got %b want 0", busy); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (bcd !== e || bcd !== 12'h255) begin errors++; $display("FAIL single_bcd: got %h want %h", bcd, e); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b want 0", done); end
  endtask

  task automatic test_values();
    bit got;
    int bc, cyc;
    logic [4*D-1:0] e;
    int vals[7] = '{0, 9, 100, 7, 70, 0, 200};
    foreach (vals[i]) begin
      launch(W'(vals[i]));
      wait_done(30, got, bc, cyc);
      checks++; if (got !== 1'b1) begin errors++; $display("FAIL value_done[%0d]: got %b want 1", vals[i], got); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++; if (bcd !== e) begin errors++; $display("FAIL value_bcd[%0d]: got %h want %h", vals[i], bcd, e); end
`ifdef BCD_BLANK_EN
      checks++; if (blank !== blank_of(vals[i])) begin errors++; $display("FAIL value_blank[%0d]: got %b want %b", vals[i], blank, blank_of(vals[i])); end
`endif
    end
  endtask

  task automatic test_ignore_start();
    bit got;
    int bc, cyc, extra_done, extra_busy;
    logic [4*D-1:0] e;
    launch(8'd42);
    @(posedge clk);           // edge 1
    @(posedge clk);           // edge 2
    #1;
    start = 1'b1;
    bin   = 8'd77;
    @(posedge clk);           // edge 3: must be ignored
    #1;
    start = 1'b0;
    wait_done(30, got, bc, cyc);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL ignore_done: got %b want 1", got); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (bcd !== e || bcd !== 12'h042) begin errors++; $display("FAIL ignore_bcd: got %h want %h", bcd, e); end
    extra_done = 0;
    extra_busy = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) extra_done++;
      if (busy) extra_busy++;
    end
    checks++; if (extra_done != 0) begin errors++; $display("FAIL ignore_no_second_done: got %0d want 0", extra_done); end
    checks++; if (extra_busy != 0) begin errors++; $display("FAIL ignore_no_second_busy: got %0d want 0", extra_busy); end
    checks++; if (bcd !== 12'h042) begin errors++; $display("FAIL ignore_bcd_held: got %h want 042", bcd); end
  endtask

  // start held high: each new operand is presented during the done cycle,
  // which is the idle cycle that accepts the next conversion.
  task automatic test_back_to_back();
    bit got;
    int bc, cyc;
    logic [4*D-1:0] e;
    start = 1'b1;
    bin   = 8'd0;
    exp_q.push_back(to_bcd(0));
    for (int i = 0; i < 256; i++) begin
      wait_done(40, got, bc, cyc);
      checks++;
      if (got !== 1'b1) begin
        errors++;
        $display("FAIL b2b_done[%0d]: got %b want 1", i, got);
        break;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      checks++; if (bcd !== e) begin errors++; $display("FAIL b2b_bcd[%0d]: got %h want %h", i, bcd, e); end
      checks++; if (cyc != W + 1) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, cyc, W + 1); end
      checks++; if (bc != W) begin errors++; $display("FAIL b2b_busy[%0d]: got %0d want %0d", i, bc, W); end
      if (i < 255) begin
        bin = W'(i + 1);
        exp_q.push_back(to_bcd(i + 1));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    exp_q.delete();
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit got;
    int bc, cyc, extra;
    logic [4*D-1:0] e;
    launch(8'd200);
    repeat (4) @(posedge clk);   // edges 1..4
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    checks++; if (bcd !== '0) begin errors++; $display("FAIL midrst_bcd: got %h want 000", bcd); end
`ifdef BCD_BLANK_EN
    checks++; if (blank !== 3'b110) begin errors++; $display("FAIL midrst_blank: got %b want 110", blank); end
`endif
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL midrst_no_done: got %0d want 0", extra); end
    launch(8'd7);
    wait_done(30, got, bc, cyc);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL midrst_restart_done: got %b want 1", got); end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++; if (bcd !== e || bcd !== 12'h007) begin errors++; $display("FAIL midrst_restart_bcd: got %h want %h", bcd, e); end
`ifdef BCD_BLANK_EN
    checks++; if (blank !== 3'b110) begin errors++; $display("FAIL midrst_restart_blank: got %b want 110", blank); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_values();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
